// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter with configurable framing
module uart_tx_param #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          wr_valid,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          wr_ready,
  output logic                          uart_txd,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {DISABLED, IDLE, START, DATA, PAR, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [DATA_BITS-1:0] dat, dat_n;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic live, push, pop, tick, last_stop, txd_n;
  assign tick      = cnt == CW'(DIV - 1);
  assign last_stop = idx == 3'(STOP_BITS - 1);
  assign busy      = state inside {START, DATA, PAR, STOP};
  assign done      = en && state == STOP && tick && last_stop;
  assign wr_ready  = live && en && fifo_count < (AW+1)'(FIFO_DEPTH);
  assign push      = wr_valid && wr_ready;
  assign dat_n     = pop ? mem[rd_ptr] : dat;
  assign txd_n     = state_n == START ? 1'b0 :
                     state_n == DATA  ? dat_n[idx_n] :
                     state_n == PAR   ? ((^dat_n) ^ (PARITY == 1)) : 1'b1;
  // Next state, bit-period counter, bit index and FIFO pop; en=0 overrides everything
  always_comb begin
    state_n = state;
    cnt_n   = busy ? (tick ? '0 : cnt + 1'b1) : '0;
    idx_n   = idx;
    pop     = 1'b0;
    case (state)
      DISABLED: state_n = IDLE;
      IDLE: if (fifo_count != 0) begin
        pop     = 1'b1;
        state_n = START;
      end
      START: if (tick) begin
        state_n = DATA;
        idx_n   = '0;
      end
      DATA: if (tick) begin
        state_n = idx == 3'(DATA_BITS - 1) ? (PARITY != 0 ? PAR : STOP) : DATA;
        idx_n   = idx == 3'(DATA_BITS - 1) ? '0 : idx + 1'b1;
      end
      PAR: if (tick) begin
        state_n = STOP;
        idx_n   = '0;
      end
      STOP: if (tick) begin
        idx_n   = last_stop ? '0 : idx + 1'b1;
        pop     = last_stop && fifo_count != 0;
        state_n = !last_stop ? STOP : fifo_count != 0 ? START : IDLE;
      end
      default: state_n = DISABLED;
    endcase
    if (!en) begin
      state_n = DISABLED;
      cnt_n   = '0;
      idx_n   = '0;
      pop     = 1'b0;
    end
  end
  // Frame state and registered line output; live marks the first clock after reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= DISABLED;
      cnt      <= '0;
      idx      <= '0;
      dat      <= '0;
      uart_txd <= 1'b1;
      live     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      dat      <= dat_n;
      uart_txd <= txd_n;
      live     <= 1'b1;
    end
  // FIFO pointers and occupancy, flushed while disabled
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (!en) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= rd_ptr + AW'(pop);
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // FIFO storage
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: randomized bench against a waveform-queue model of the UART line
module tb_uart_tx_param;
  localparam int CLK_HZ = 1000000, BAUD = 115200, DB = 8, PAR = 1, SB = 2, DEPTH = 4;
  localparam int DIV  = 8;
  localparam int FLEN = (1 + DB + 1 + SB) * DIV;
  logic clk = 0, rst = 0, en = 0, wr_valid = 0;
  logic [7:0] wr_data = 0;
  logic wr_ready, uart_txd, busy, done;
  logic [2:0] fifo_count;
  int errors = 0, checks = 0;
  int n_done = 0, saw_full = 0;
  logic [7:0] mq[$];
  bit wave[$];
  bit off = 1, up = 0;

  uart_tx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DB), .PARITY(PAR),
                  .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .uart_txd(uart_txd), .busy(busy), .done(done),
    .fifo_count(fifo_count));

  always #5 clk = ~clk;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expand one character into its per-cycle line levels
  function automatic void load(logic [7:0] d);
    int ones = $countones(d);
    bit p = (PAR == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    repeat (DIV) wave.push_back(1'b0);
    for (int i = 0; i < DB; i++) repeat (DIV) wave.push_back(d[i]);
    if (PAR != 0) repeat (DIV) wave.push_back(p);
    repeat (SB * DIV) wave.push_back(1'b1);
  endfunction

  // Model: a character queue and the remaining waveform of the frame on the line
  always @(posedge clk or negedge rst) begin
    bit psh;
    if (!rst) begin
      up = 0; off = 1; mq.delete(); wave.delete();
    end else begin
      psh = up && en && wr_valid && mq.size() < DEPTH;
      up = 1;
      if (!en) begin
        off = 1; mq.delete(); wave.delete();
      end else begin
        if (off) off = 0;
        else begin
          if (wave.size() > 0) void'(wave.pop_front());
          if (wave.size() == 0 && mq.size() > 0) load(mq.pop_front());
        end
        if (psh) mq.push_back(wr_data);
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    check("txd", uart_txd, wave.size() > 0 ? int'(wave[0]) : 1);
    check("busy", busy, int'(wave.size() > 0));
    check("done", done, int'(wave.size() == 1 && en));
    check("fifo_count", fifo_count, mq.size());
    check("wr_ready", wr_ready, int'(up && en && mq.size() < DEPTH));
    n_done += int'(done);
    if (en && fifo_count == 4 && !wr_ready) saw_full = 1;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(logic [7:0] d);
    int t = 0;
    wr_valid = 1; wr_data = d;
    while (!wr_ready && t < 400) begin step(); t++; end
    check("push_timeout", int'(t < 400), 1);
    step();
    wr_valid = 0;
  endtask

  task automatic grab(output int len, output logic [11:0] sym);
    int t = 0;
    len = 0; sym = '0;
    do begin @(negedge clk); t++; end while (!busy && t < 300);
    check("grab_start", busy, 1);
    while (busy && len < 300) begin
      if (len % DIV == DIV / 2 && len / DIV < 12) sym[len / DIV] = uart_txd;
      len++;
      @(negedge clk);
    end
    step();
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || fifo_count != 0 || !wr_ready) && t < 3000) begin step(); t++; end
    check("idle_timeout", int'(t < 3000), 1);
  endtask

  initial begin
    int len, base, gaps, t;
    logic [11:0] sym;
    en = 1;
    repeat (3) step();
    check("rst_txd", uart_txd, 1);
    check("rst_ready", wr_ready, 0);
    check("rst_busy", busy, 0);
    #2 rst = 1;
    step(); step();
    check("ready_after_rst", wr_ready, 1);
    push(8'hA5); grab(len, sym);
    check("len_a5", len, FLEN);
    check("sym_a5", sym, 12'hF4A);
    push(8'h07); grab(len, sym);
    check("len_07", len, 96);
    check("sym_07", sym, 12'hC0E);
    base = n_done; saw_full = 0;
    for (int i = 0; i < 5; i++) push(8'($urandom));
    gaps = 0; t = 0;
    while (n_done - base < 5 && t < 6 * FLEN) begin
      if (!busy) gaps++;
      step(); t++;
    end
    check("b2b_done", n_done - base, 5);
    check("b2b_gaps", gaps, 0);
    check("b2b_full", saw_full, 1);
    wait_idle();
    base = n_done;
    for (int i = 0; i < 3; i++) push(8'($urandom));
    repeat (3 * DIV) step();
    check("drop_queued", fifo_count, 2);
    en = 0;
    step();
    @(negedge clk);
    check("drop_txd", uart_txd, 1);
    check("drop_count", fifo_count, 0);
    check("drop_busy", busy, 0);
    check("drop_done", n_done - base, 0);
    step();
    en = 1;
    for (int c = 0; c < 2500; c++) begin
      en = $urandom_range(0, 299) != 0;
      wr_valid = c < 1200 ? $urandom_range(0, 1) == 0 : $urandom_range(0, 19) == 0;
      wr_data = 8'($urandom);
      step();
    end
    en = 1; wr_valid = 0;
    wait_idle();
    push(8'h3C);
    step(); step();
    check("start_low", uart_txd, 0);
    #2 rst = 0;
    #1;
    check("async_txd", uart_txd, 1);
    check("async_busy", busy, 0);
    check("async_count", fifo_count, 0);
    step();
    rst = 1;
    step(); step();
    push(8'h07); grab(len, sym);
    check("len_after_rst", len, 96);
    check("sym_after_rst", sym, 12'hC0E);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL expose parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 The block SHALL expose parameter BAUD, default 115200, line rate in bit/s.
REQ-003 The block SHALL expose parameter DATA_BITS, default 8, legal range 5-8, payload bits per frame.
REQ-004 The block SHALL expose parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-005 The block SHALL expose parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 The block SHALL expose parameter FIFO_DEPTH, default 4, a power of two between 2 and 16.
REQ-007 clk  input  1  sole clock; all state changes on its rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-009 en  input  1  block enable; 0 holds the block disabled.
REQ-010 wr_valid  input  1  producer offers wr_data this cycle.
REQ-011 wr_data  input  DATA_BITS  payload character.
REQ-012 wr_ready  output  1  FIFO accepts a character this cycle.
REQ-013 uart_txd  output  1  serial line; idle high; registered.
REQ-014 busy  output  1  a frame is on the line (START through last STOP).
REQ-015 done  output  1  one-cycle pulse at the end of each frame.
REQ-016 fifo_count  output  clog2(FIFO_DEPTH)+1  number of queued characters.

Function
REQ-017 Bit period DIV SHALL be CLK_HZ/BAUD, integer-truncated (868 at defaults); each line symbol SHALL last exactly DIV cycles, counted 0..DIV-1.
REQ-018 The FSM SHALL have states DISABLED, IDLE, START, DATA, PAR, STOP; any unused encoding SHALL go to DISABLED.
REQ-019 en=0 (sampled on the clock edge) SHALL force DISABLED, flush the FIFO (fifo_count=0), clear the counters, and drive uart_txd=1 on the following cycle, even mid-frame.
REQ-020 DISABLED with en=1 SHALL go to IDLE on the next cycle.
REQ-021 wr_ready SHALL equal en AND (fifo_count < FIFO_DEPTH); a push occurs when wr_valid AND wr_ready.
REQ-022 wr_valid while full SHALL be ignored; the data SHALL NOT be written and the count SHALL NOT change.
REQ-023 IDLE with fifo_count>0 SHALL pop the head into a shift register and enter START on the next edge.
REQ-024 A push and a pop in the same cycle SHALL leave fifo_count unchanged; push-to-empty data is poppable the following cycle at earliest.
REQ-025 START SHALL drive 0 for one bit period, then enter DATA.
REQ-026 DATA SHALL send DATA_BITS bits LSB first, one per bit period, then enter PAR if PARITY!=0, else STOP.
REQ-027 PAR SHALL send one bit making the total count of ones (data+parity) odd for PARITY=1 and even for PARITY=2.
REQ-028 STOP SHALL drive 1 for STOP_BITS bit periods.
REQ-029 uart_txd SHALL be 1 in DISABLED, IDLE and STOP, and SHALL change only on bit-period boundaries while busy.
REQ-030 done SHALL pulse high for exactly the one cycle in which the last STOP period completes.
REQ-031 At the end of STOP, if fifo_count>0, the block SHALL pop and enter START directly with no idle cycle; otherwise it SHALL enter IDLE.
REQ-032 Frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*DIV cycles.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH or underflow.

Reset
REQ-034 rst=0 SHALL immediately (asynchronously) force state DISABLED, uart_txd=1, busy=0, done=0, fifo_count=0, wr_ready=0, and all counters and pointers to 0.
REQ-035 After rst rises, with en=1, the block SHALL reach IDLE on the second rising edge and assert wr_ready.
REQ-036 Reset asserted mid-frame SHALL abort the frame and discard queued data; no done pulse SHALL be emitted.

Verification
REQ-037 Defaults, push 0x55 -> txd low 868 cycles, bits 1,0,1,0,1,0,1,0 at 868 each, high 868; done at cycle 8680 of the frame; busy high throughout.
REQ-038 PARITY=2, push 0xA5 -> parity bit 0; PARITY=1, same data -> parity bit 1; frame 11*868 cycles.
REQ-039 DATA_BITS=7, STOP_BITS=2, push 0x7F -> 7 data ones, stop high 1736 cycles, 10 periods total.
REQ-040 Push 5 bytes back-to-back with FIFO_DEPTH=4 -> wr_ready low when fifo_count=4 after the first pop; frames contiguous with no idle gap; 5 done pulses.
REQ-041 Drop en during DATA of a frame with 2 queued -> next cycle txd=1, fifo_count=0, busy=0; no done pulse.
REQ-042 Assert rst mid-START -> txd=1 with no clock edge; after release, idle high and first new frame bit-exact.
